h_bdy_sched: RTL and testbench

// - Shares the single h_bdy_eng command port between N_REQ requesters.
// - Round-robin arbitration; one registered issue slot toward the engine.
// - Credit-limits in-flight engine ops to MAX_OUT.
// - Routes each engine completion back to its requester by ID; supports flush/drain.
//

---
 rtl/h_bdy_sched.sv | 135 +++++++++++++
 tb/tb_h_bdy_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/h_bdy_sched.sv
// Round-robin scheduler sharing one h_bdy_eng command port between N_REQ requesters,
// with a registered issue slot, in-flight credit limit, completion routing and flush/drain.
module h_bdy_sched #(
  parameter int N_REQ   = 4,
  parameter int DAT_W   = 32,
  parameter int MAX_OUT = 8,
  localparam int ID_W   = $clog2(N_REQ),
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic [N_REQ-1:0]       req_vld_i,
  input  logic [N_REQ*DAT_W-1:0] req_dat_i,
  output logic [N_REQ-1:0]       req_rdy_o,
  output logic                   eng_vld_o,
  output logic [DAT_W-1:0]       eng_dat_o,
  output logic [ID_W-1:0]        eng_id_o,
  input  logic                   eng_rdy_i,
  input  logic                   cpl_vld_i,
  input  logic [ID_W-1:0]        cpl_id_i,
  output logic [N_REQ-1:0]       cpl_vld_o,
  input  logic                   flush_i,
  output logic                   flush_done_o,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       outstanding_o,
  output logic                   err_o
);

  // S_HOLD waits for flush_i to drop after the done pulse, so a held flush pulses only once.
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               eng_vld_q, eng_vld_d;
  logic [DAT_W-1:0]   eng_dat_q, eng_dat_d;
  logic [ID_W-1:0]    eng_id_q, eng_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   cpl_q, cpl_d;
  logic               err_q, err_d;

  logic               slot_free, issue, grant_en, grant, found, cpl_ok, empty_next;
  logic [ID_W-1:0]    win, idx;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    eng_vld_d = eng_vld_q;
    eng_dat_d = eng_dat_q;
    eng_id_d  = eng_id_q;
    cnt_d     = cnt_q;
    cpl_d     = '0;
    err_d     = err_q;
    req_rdy_o = '0;
    found     = 1'b0;
    win       = '0;
    idx       = '0;

    slot_free = ~eng_vld_q | eng_rdy_i;
    issue     = eng_vld_q & eng_rdy_i;
    grant_en  = ~srst & (state_q == S_RUN) & ~flush_i & slot_free &
                (({1'b0, cnt_q} + (CNT_W+1)'(eng_vld_q)) < (CNT_W+1)'(MAX_OUT));

    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!found && req_vld_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant = grant_en & found;

    if (grant) begin
      req_rdy_o[win] = 1'b1;
      eng_vld_d      = 1'b1;
      eng_dat_d      = req_dat_i[win*DAT_W +: DAT_W];
      eng_id_d       = win;
      ptr_d          = win;
    end else if (eng_rdy_i) begin
      eng_vld_d = 1'b0;
    end

    cpl_ok = cpl_vld_i & (32'(cpl_id_i) < 32'(N_REQ)) & (cnt_q != '0);
    if (cpl_vld_i && !cpl_ok) err_d = 1'b1;
    if (cpl_ok) cpl_d[cpl_id_i] = 1'b1;

    case ({issue, cpl_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    empty_next = ~eng_vld_d & (cnt_d == '0);

    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (flush_i) state_d = empty_next ? S_DONE : S_DRAIN;
      S_DRAIN: if (empty_next) state_d = S_DONE;
      S_DONE:  state_d = flush_i ? S_HOLD : S_RUN;
      S_HOLD:  if (!flush_i) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= S_IDLE;
      ptr_q     <= ID_W'(N_REQ - 1);
      eng_vld_q <= 1'b0;
      eng_dat_q <= '0;
      eng_id_q  <= '0;
      cnt_q     <= '0;
      cpl_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      eng_vld_q <= eng_vld_d;
      eng_dat_q <= eng_dat_d;
      eng_id_q  <= eng_id_d;
      cnt_q     <= cnt_d;
      cpl_q     <= cpl_d;
      err_q     <= err_d;
    end
  end

  assign eng_vld_o     = eng_vld_q;
  assign eng_dat_o     = eng_dat_q;
  assign eng_id_o      = eng_id_q;
  assign cpl_vld_o     = cpl_q;
  assign flush_done_o  = (state_q == S_DONE);
  assign busy_o        = eng_vld_q | (cnt_q != '0);
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_h_bdy_sched.sv
// Randomized scoreboard bench for h_bdy_sched against a behavioural reference model.
module tb_h_bdy_sched;

  localparam int N_REQ   = 4;
  localparam int DAT_W   = 32;
  localparam int MAX_OUT = 8;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 4;

  logic                   clk;
  logic                   srst;
  logic [N_REQ-1:0]       req_vld_i;
  logic [N_REQ*DAT_W-1:0] req_dat_i;
  logic [N_REQ-1:0]       req_rdy_o;
  logic                   eng_vld_o;
  logic [DAT_W-1:0]       eng_dat_o;
  logic [ID_W-1:0]        eng_id_o;
  logic                   eng_rdy_i;
  logic                   cpl_vld_i;
  logic [ID_W-1:0]        cpl_id_i;
  logic [N_REQ-1:0]       cpl_vld_o;
  logic                   flush_i;
  logic                   flush_done_o;
  logic                   busy_o;
  logic [CNT_W-1:0]       outstanding_o;
  logic                   err_o;

  h_bdy_sched #(.N_REQ(N_REQ), .DAT_W(DAT_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .srst(srst), .req_vld_i(req_vld_i), .req_dat_i(req_dat_i),
    .req_rdy_o(req_rdy_o), .eng_vld_o(eng_vld_o), .eng_dat_o(eng_dat_o),
    .eng_id_o(eng_id_o), .eng_rdy_i(eng_rdy_i), .cpl_vld_i(cpl_vld_i),
    .cpl_id_i(cpl_id_i), .cpl_vld_o(cpl_vld_o), .flush_i(flush_i),
    .flush_done_o(flush_done_o), .busy_o(busy_o), .outstanding_o(outstanding_o),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues: commands the engine must see, completions requesters must see.
  logic [DAT_W+ID_W-1:0] eng_q[$];
  logic [N_REQ-1:0]      cpl_q[$];
  int                    inflight[$];

  // Reference model: the issue slot, requester pointer, in-flight count, flush progress.
  bit               m_vld;
  logic [DAT_W-1:0] m_dat;
  int               m_id, m_ptr, m_cnt;
  bit               m_err, m_live, m_drain, m_pulse, m_hold;
  logic [N_REQ-1:0] m_cpl_out;

  // Stimulus knobs.
  bit s_rst, s_flush, s_err;
  int p_vld, p_rdy, p_cpl, p_flip;

  task automatic model_reset();
    m_vld = 0; m_dat = '0; m_id = 0; m_ptr = N_REQ - 1; m_cnt = 0; m_err = 0;
    m_live = 0; m_drain = 0; m_pulse = 0; m_hold = 0; m_cpl_out = '0;
    eng_q.delete(); inflight.delete();
  endtask

  task automatic cycle();
    logic [N_REQ-1:0] exp_rdy;
    bit can, found, issue, cok, n_vld, empty;
    int w, n_cnt, pick;
    @(posedge clk); #1;
    chk("eng_vld", eng_vld_o, m_vld);
    chk("outstanding", outstanding_o, m_cnt);
    chk("busy", busy_o, (m_vld || m_cnt != 0));
    chk("err", err_o, m_err);
    chk("flush_done", flush_done_o, m_pulse);
    chk("cpl_vld_now", cpl_vld_o, m_cpl_out);

    if (p_flip > 0 && $urandom_range(99) < p_flip) s_flush = ~s_flush;
    srst    = s_rst;
    flush_i = s_flush;
    for (int i = 0; i < N_REQ; i++) begin
      req_vld_i[i] = ($urandom_range(99) < p_vld);
      req_dat_i[i*DAT_W +: DAT_W] = $urandom;
    end
    eng_rdy_i = ($urandom_range(99) < p_rdy);
    cpl_vld_i = 1'b0;
    cpl_id_i  = ID_W'($urandom_range(N_REQ - 1));
    if (!s_rst && inflight.size() > 0 && $urandom_range(99) < p_cpl) begin
      pick      = $urandom_range(inflight.size() - 1);
      cpl_vld_i = 1'b1;
      cpl_id_i  = ID_W'(inflight[pick]);
      inflight.delete(pick);
    end else if (!s_rst && s_err && m_cnt == 0) begin
      cpl_vld_i = 1'b1;
    end
    #1;

    exp_rdy = '0;
    if (srst) begin
      chk("req_rdy", req_rdy_o, exp_rdy);
      model_reset();
      return;
    end
    can = m_live && !m_drain && !m_pulse && !m_hold && !flush_i &&
          (!m_vld || eng_rdy_i) && (m_cnt + int'(m_vld) < MAX_OUT);
    found = 0; w = 0;
    for (int k = 1; k <= N_REQ; k++)
      if (!found && req_vld_i[(m_ptr + k) % N_REQ]) begin
        found = 1; w = (m_ptr + k) % N_REQ;
      end
    if (can && found) exp_rdy[w] = 1'b1;
    chk("req_rdy", req_rdy_o, exp_rdy);

    issue = m_vld && eng_rdy_i;
    cok   = cpl_vld_i && m_cnt > 0;
    if (cpl_vld_i && !cok) m_err = 1;
    if (issue) inflight.push_back(m_id);
    n_cnt = m_cnt + int'(issue) - int'(cok);
    m_cpl_out = '0;
    if (cok) begin
      m_cpl_out[cpl_id_i] = 1'b1;
      cpl_q.push_back(m_cpl_out);
    end
    n_vld = m_vld;
    if (can && found) begin
      n_vld = 1; m_dat = req_dat_i[w*DAT_W +: DAT_W]; m_id = w; m_ptr = w;
      eng_q.push_back({m_dat, ID_W'(w)});
    end else if (eng_rdy_i) begin
      n_vld = 0;
    end
    empty = (n_cnt == 0) && !n_vld;
    if (!m_live)      m_live = 1;
    else if (m_pulse) begin m_pulse = 0; m_hold = flush_i; end
    else if (m_hold)  m_hold = flush_i;
    else if (m_drain) begin if (empty) begin m_drain = 0; m_pulse = 1; end end
    else if (flush_i) begin if (empty) m_pulse = 1; else m_drain = 1; end
    m_vld = n_vld;
    m_cnt = n_cnt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: whatever the DUT presents is popped from the scoreboard and compared.
  initial begin
    logic [DAT_W+ID_W-1:0] e;
    logic [N_REQ-1:0]      c;
    forever begin
      @(negedge clk);
      if (eng_vld_o && eng_rdy_i && !srst) begin
        if (eng_q.size() == 0) chk("eng_unexpected", 1, 0);
        else begin
          e = eng_q.pop_front();
          chk("eng_dat", eng_dat_o, e[DAT_W+ID_W-1:ID_W]);
          chk("eng_id", eng_id_o, e[ID_W-1:0]);
        end
      end
      if (cpl_vld_o != '0) begin
        if (cpl_q.size() == 0) chk("cpl_unexpected", cpl_vld_o, 0);
        else begin
          c = cpl_q.pop_front();
          chk("cpl_route", cpl_vld_o, c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1; req_vld_i = '0; req_dat_i = '0; eng_rdy_i = 0; cpl_vld_i = 0;
    cpl_id_i = '0; flush_i = 0;
    model_reset();
    s_rst = 1; s_flush = 0; s_err = 0; p_flip = 0;
    p_vld = 100; p_rdy = 100; p_cpl = 0;
    run(3);
    s_rst = 0;
    run(15);                                   // all requesting, credits saturate
    p_cpl = 30; run(10);
    p_rdy = 0; run(6); p_rdy = 100; run(4);    // engine stall then release
    p_vld = 60; p_rdy = 70; p_cpl = 40; run(300);
    s_flush = 1; run(30); s_flush = 0; run(20);
    p_flip = 5; run(400); p_flip = 0; s_flush = 0; run(5);
    p_vld = 0; p_rdy = 100; p_cpl = 100; run(20);
    s_err = 1; run(2); s_err = 0; run(5);
    p_vld = 70; p_rdy = 80; p_cpl = 40; run(20);
    s_rst = 1; run(1); s_rst = 0; run(50);
    s_flush = 1; p_vld = 100; run(30); s_flush = 0; run(30);
    p_vld = 0; p_cpl = 100; run(20);
    @(negedge clk); #1;
    chk("cpl_q_empty", cpl_q.size(), 0);
    chk("eng_q_left", eng_q.size(), int'(m_vld));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
